// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: IF/ID/EX/MEM/WB sequencer with
// combinational strobes and a retired-instruction counter.
module multicycle_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Function_opcode,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        IR_write,
  output logic        PC_write,
  output logic [1:0]  PC_src,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic        I_format,
  output logic        Sftmd,
  output logic        Jr,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        Jal,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t      state_reg, state_next, cur_state;
  logic [31:0] count_reg;
  logic        retire;
  logic        ready;

  logic is_r, is_jr, is_shift, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_ifmt, is_legal;

  assign is_r     = (Opcode == 6'b000000);
  assign is_jr    = is_r && (Function_opcode == 6'b001000);
  assign is_shift = is_r && ((Function_opcode == 6'b000000) || (Function_opcode == 6'b000010) ||
                             (Function_opcode == 6'b000011) || (Function_opcode == 6'b000100) ||
                             (Function_opcode == 6'b000110) || (Function_opcode == 6'b000111));
  assign is_lw    = (Opcode == 6'b100011);
  assign is_sw    = (Opcode == 6'b101011);
  assign is_beq   = (Opcode == 6'b000100);
  assign is_bne   = (Opcode == 6'b000101);
  assign is_j     = (Opcode == 6'b000010);
  assign is_jal   = (Opcode == 6'b000011);
  assign is_ifmt  = (Opcode[5:3] == 3'b001);
  assign is_legal = is_r | is_lw | is_sw | is_beq | is_bne | is_j | is_jal | is_ifmt;

  // Under reset the strobes look like an idle fetch, whatever state is held.
  assign cur_state = reset ? S_IF : state_reg;
  assign ready     = mem_ready & ~reset;

  always_comb begin
    IR_write   = 1'b0;
    PC_write   = 1'b0;
    PC_src     = 2'b00;
    ALUOp      = 2'b00;
    ALUSrc     = 1'b0;
    I_format   = 1'b0;
    Sftmd      = 1'b0;
    Jr         = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    Jal        = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    state_next = state_reg;
    case (cur_state)
      S_IF: begin
        IR_write = ready;
        PC_write = ready;
        if (ready) state_next = S_ID;
      end
      S_ID: begin
        state_next = S_IF;
        if (!is_legal) begin
          illegal = 1'b1;
        end else if (is_j || is_jal) begin
          PC_write = 1'b1;
          PC_src   = 2'b10;
          RegWrite = is_jal;
          Jal      = is_jal;
          retire   = 1'b1;
        end else if (is_jr) begin
          Jr       = 1'b1;
          PC_write = 1'b1;
          PC_src   = 2'b11;
          retire   = 1'b1;
        end else begin
          state_next = S_EX;
        end
      end
      S_EX: begin
        ALUOp    = {is_r | is_ifmt, is_beq | is_bne};
        ALUSrc   = is_ifmt | is_lw | is_sw;
        I_format = is_ifmt;
        Sftmd    = is_shift;
        if (is_beq || is_bne) begin
          PC_write   = is_beq ? Zero : ~Zero;
          PC_src     = 2'b01;
          retire     = 1'b1;
          state_next = S_IF;
        end else if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else if (is_r || is_ifmt) begin
          state_next = S_WB;
        end else begin
          state_next = S_IF;
        end
      end
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        ALUSrc   = 1'b1;
        if (ready) begin
          if (is_lw) begin
            state_next = S_WB;
          end else begin
            retire     = is_sw;
            state_next = S_IF;
          end
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        RegDst     = is_r;
        MemtoReg   = is_lw;
        retire     = 1'b1;
        state_next = S_IF;
      end
      default: state_next = S_IF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IF;
      count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (retire) count_reg <= count_reg + 32'd1;
    end
  end

  assign state       = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: walks each instruction class
// cycle by cycle and compares state, strobes and retired count.
module tb_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  Opcode, Function_opcode;
  logic        Zero, mem_ready;
  logic        IR_write, PC_write, ALUSrc, I_format, Sftmd, Jr;
  logic        RegWrite, RegDst, MemtoReg, Jal, MemRead, MemWrite, illegal;
  logic [1:0]  PC_src, ALUOp;
  logic [2:0]  state;
  logic [31:0] instr_count;
  logic [16:0] outs;

  int n_vec = 0;
  int n_err = 0;

  // Strobe bit masks within outs.
  localparam logic [16:0] IRW    = 17'h10000;
  localparam logic [16:0] PCW    = 17'h08000;
  localparam logic [16:0] SRC_BR = 17'h02000;
  localparam logic [16:0] SRC_J  = 17'h04000;
  localparam logic [16:0] SRC_JR = 17'h06000;
  localparam logic [16:0] OP_RI  = 17'h01000;
  localparam logic [16:0] OP_BR  = 17'h00800;
  localparam logic [16:0] ASRC   = 17'h00400;
  localparam logic [16:0] IFMT   = 17'h00200;
  localparam logic [16:0] SFT    = 17'h00100;
  localparam logic [16:0] JRB    = 17'h00080;
  localparam logic [16:0] RW     = 17'h00040;
  localparam logic [16:0] RD     = 17'h00020;
  localparam logic [16:0] M2R    = 17'h00010;
  localparam logic [16:0] JALB   = 17'h00008;
  localparam logic [16:0] MR     = 17'h00004;
  localparam logic [16:0] MW     = 17'h00002;
  localparam logic [16:0] ILL    = 17'h00001;

  multicycle_ctrl dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .Function_opcode(Function_opcode),
    .Zero(Zero), .mem_ready(mem_ready), .IR_write(IR_write), .PC_write(PC_write),
    .PC_src(PC_src), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .I_format(I_format), .Sftmd(Sftmd),
    .Jr(Jr), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .Jal(Jal),
    .MemRead(MemRead), .MemWrite(MemWrite), .illegal(illegal), .state(state),
    .instr_count(instr_count)
  );

  assign outs = {IR_write, PC_write, PC_src, ALUOp, ALUSrc, I_format, Sftmd, Jr,
                 RegWrite, RegDst, MemtoReg, Jal, MemRead, MemWrite, illegal};

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: compare mid-cycle, then advance past the next edge.
  task automatic step(input string tag, input logic [2:0] es, input logic [16:0] eo);
    @(negedge clock);
    chk({tag, ".state"}, 32'(state), 32'(es));
    chk({tag, ".outs"}, 32'(outs), 32'(eo));
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_decode(input string tag);
    step({tag, ".IF"}, 3'd0, IRW | PCW);
    step({tag, ".ID"}, 3'd1, 17'h0);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    Opcode          = op;
    Function_opcode = fn;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
    set_instr(6'b000000, 6'b100000);
    @(posedge clock); #1;
    step("reset", 3'd0, 17'h0);
    chk("reset.cnt", instr_count, 32'd0);
    reset = 1'b0; mem_ready = 1'b0;
    step("if_wait", 3'd0, 17'h0);
    $display("reset and fetch wait done, count=%0d", instr_count);

    // add
    mem_ready = 1'b1;
    fetch_decode("add");
    step("add.EX", 3'd2, OP_RI);
    step("add.WB", 3'd4, RW | RD);
    chk("add.cnt", instr_count, 32'd1);
    $display("add retired, count=%0d", instr_count);

    // lw with two memory wait cycles
    set_instr(6'b100011, 6'b000000);
    fetch_decode("lw");
    step("lw.EX", 3'd2, ASRC);
    mem_ready = 1'b0;
    step("lw.MEM0", 3'd3, MR | ASRC);
    step("lw.MEM1", 3'd3, MR | ASRC);
    mem_ready = 1'b1;
    step("lw.MEM2", 3'd3, MR | ASRC);
    step("lw.WB", 3'd4, RW | M2R);
    chk("lw.back", 32'(state), 32'd0);
    chk("lw.cnt", instr_count, 32'd2);
    $display("lw retired, count=%0d", instr_count);

    // beq taken, beq not taken, bne not-equal
    set_instr(6'b000100, 6'b000000);
    fetch_decode("beq1");
    Zero = 1'b1;
    step("beq1.EX", 3'd2, OP_BR | PCW | SRC_BR);
    chk("beq1.cnt", instr_count, 32'd3);
    $display("beq taken retired, count=%0d", instr_count);
    fetch_decode("beq0");
    Zero = 1'b0;
    step("beq0.EX", 3'd2, OP_BR | SRC_BR);
    chk("beq0.cnt", instr_count, 32'd4);
    $display("beq not taken retired, count=%0d", instr_count);
    set_instr(6'b000101, 6'b000000);
    fetch_decode("bne");
    step("bne.EX", 3'd2, OP_BR | PCW | SRC_BR);
    chk("bne.cnt", instr_count, 32'd5);
    $display("bne retired, count=%0d", instr_count);

    // jal, j, jr resolve in ID
    set_instr(6'b000011, 6'b000000);
    step("jal.IF", 3'd0, IRW | PCW);
    step("jal.ID", 3'd1, PCW | SRC_J | RW | JALB);
    chk("jal.back", 32'(state), 32'd0);
    chk("jal.cnt", instr_count, 32'd6);
    $display("jal retired, count=%0d", instr_count);
    set_instr(6'b000010, 6'b000000);
    step("j.IF", 3'd0, IRW | PCW);
    step("j.ID", 3'd1, PCW | SRC_J);
    chk("j.cnt", instr_count, 32'd7);
    $display("j retired, count=%0d", instr_count);
    set_instr(6'b000000, 6'b001000);
    step("jr.IF", 3'd0, IRW | PCW);
    step("jr.ID", 3'd1, JRB | PCW | SRC_JR);
    chk("jr.cnt", instr_count, 32'd8);
    $display("jr retired, count=%0d", instr_count);

    // sll (shift) and addi (I-format)
    set_instr(6'b000000, 6'b000000);
    fetch_decode("sll");
    step("sll.EX", 3'd2, OP_RI | SFT);
    step("sll.WB", 3'd4, RW | RD);
    chk("sll.cnt", instr_count, 32'd9);
    $display("sll retired, count=%0d", instr_count);
    set_instr(6'b001000, 6'b000000);
    fetch_decode("addi");
    step("addi.EX", 3'd2, OP_RI | ASRC | IFMT);
    step("addi.WB", 3'd4, RW);
    chk("addi.cnt", instr_count, 32'd10);
    $display("addi retired, count=%0d", instr_count);

    // illegal opcode
    set_instr(6'b111111, 6'b000000);
    step("ill.IF", 3'd0, IRW | PCW);
    step("ill.ID", 3'd1, ILL);
    chk("ill.back", 32'(state), 32'd0);
    chk("ill.cnt", instr_count, 32'd10);
    $display("illegal opcode trapped, count=%0d", instr_count);

    // sw with no waits
    set_instr(6'b101011, 6'b000000);
    fetch_decode("sw");
    step("sw.EX", 3'd2, ASRC);
    step("sw.MEM", 3'd3, MW | ASRC);
    chk("sw.back", 32'(state), 32'd0);
    chk("sw.cnt", instr_count, 32'd11);
    $display("sw retired, count=%0d", instr_count);

    // sw interrupted by reset during a memory wait
    fetch_decode("swr");
    step("swr.EX", 3'd2, ASRC);
    mem_ready = 1'b0;
    step("swr.MEM", 3'd3, MW | ASRC);
    reset = 1'b1;
    step("swr.RST", 3'd3, 17'h0);
    reset = 1'b0;
    chk("swr.cnt", instr_count, 32'd0);
    step("swr.after", 3'd0, 17'h0);
    $display("sw aborted by reset, count=%0d", instr_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
